// File: rtl/ro_puf_response_ctrl.sv
// Response controller for the RO PUF core: walks challenge pairs through
// clear/measure/hold/compare and builds a response word plus tie mask.
module ro_puf_response_ctrl #(
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 8,
    parameter int NUM_BITS = 8,
    parameter int WINDOW   = 200,
    parameter int HOLD_CYC = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_BITS*2*SEL_W-1:0] challenge,
    input  logic [CNT_W-1:0]            count_1,
    input  logic [CNT_W-1:0]            count_2,
    output logic [SEL_W-1:0]            sel1,
    output logic [SEL_W-1:0]            sel2,
    output logic                        ro_enable,
    output logic                        ro_reset,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_BITS-1:0]         response,
    output logic [NUM_BITS-1:0]         tie_mask
);

    localparam int CH_W  = NUM_BITS * 2 * SEL_W;
    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        HOLD,
        COMPARE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]    chal_q, chal_d;
    logic [NUM_BITS-1:0] resp_q, resp_d;
    logic [NUM_BITS-1:0] tie_q, tie_d;
    logic [SEL_W-1:0]   sel1_q, sel1_d;
    logic [SEL_W-1:0]   sel2_q, sel2_d;
    logic               en_q, en_d;
    logic               rr_q, rr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    int                 base;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    resp_d  = '0;
                    tie_d   = '0;
                    idx_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = MEASURE;
            end
            MEASURE: begin
                if (cnt_q == 16'(WINDOW - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 16'(HOLD_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = COMPARE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            COMPARE: begin
                resp_d[idx_q] = (count_1 > count_2);
                tie_d[idx_q]  = (count_1 == count_2);
                if (idx_q == IDX_W'(NUM_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = CLEAR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        base   = 2 * SEL_W * int'(idx_d);
        sel1_d = sel1_q;
        sel2_d = sel2_q;
        if (state_d == CLEAR) begin
            sel1_d = chal_d[base +: SEL_W];
            sel2_d = chal_d[base + SEL_W +: SEL_W];
        end
        en_d   = (state_d == MEASURE);
        rr_d   = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            chal_q  <= '0;
            resp_q  <= '0;
            tie_q   <= '0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            en_q    <= 1'b0;
            rr_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            en_q    <= en_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel1      = sel1_q;
    assign sel2      = sel2_q;
    assign ro_enable = en_q;
    assign ro_reset  = rr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = resp_q;
    assign tie_mask  = tie_q;

endmodule

// File: tb/tb_ro_puf_response_ctrl.sv
// Directed bench: a small instance (2 bits, window 10, hold 2) and a
// default instance (8 bits, window 200, hold 4) with counts driven per pair.
module tb_ro_puf_response_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;

    logic        s_reset, s_start;
    logic [11:0] s_chal;
    logic [7:0]  s_c1, s_c2;
    logic [2:0]  s_sel1, s_sel2;
    logic        s_en, s_rr, s_busy, s_done;
    logic [1:0]  s_resp, s_tie;

    logic        d_reset, d_start;
    logic [47:0] d_chal;
    logic [7:0]  d_c1, d_c2;
    logic [2:0]  d_sel1, d_sel2;
    logic        d_en, d_rr, d_busy, d_done;
    logic [7:0]  d_resp, d_tie;

    logic [7:0] dc1 [8] = '{8'h80, 8'h00, 8'hFF, 8'h33, 8'h10, 8'hA0, 8'h01, 8'hC8};
    logic [7:0] dc2 [8] = '{8'h7F, 8'hFF, 8'h00, 8'h33, 8'h11, 8'h0A, 8'h02, 8'hC7};

    ro_puf_response_ctrl #(
        .SEL_W(3), .CNT_W(8), .NUM_BITS(2), .WINDOW(10), .HOLD_CYC(2)
    ) dut_s (
        .clk(clk), .reset(s_reset), .start(s_start), .challenge(s_chal),
        .count_1(s_c1), .count_2(s_c2), .sel1(s_sel1), .sel2(s_sel2),
        .ro_enable(s_en), .ro_reset(s_rr), .busy(s_busy), .done(s_done),
        .response(s_resp), .tie_mask(s_tie)
    );

    ro_puf_response_ctrl dut_d (
        .clk(clk), .reset(d_reset), .start(d_start), .challenge(d_chal),
        .count_1(d_c1), .count_2(d_c2), .sel1(d_sel1), .sel2(d_sel2),
        .ro_enable(d_en), .ro_reset(d_rr), .busy(d_busy), .done(d_done),
        .response(d_resp), .tie_mask(d_tie)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_reset = 1'b1; d_reset = 1'b1;
        s_start = 1'b0; d_start = 1'b0;
        s_chal = '0; d_chal = '0;
        s_c1 = '0; s_c2 = '0; d_c1 = '0; d_c2 = '0;
        step();
        step();
        total++;
        if ({s_busy, s_done, s_en, s_rr} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0001", {s_busy, s_done, s_en, s_rr});
        end
        total++;
        if ({s_sel1, s_sel2, s_resp, s_tie} !== 10'd0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {s_sel1, s_sel2, s_resp, s_tie});
        end
        total++;
        if ({d_busy, d_done, d_en, d_rr, d_sel1, d_sel2, d_resp, d_tie} !== 26'd1 << 22) begin
            fails++;
            $display("FAIL reset_dflt: got %h want %h",
                     {d_busy, d_done, d_en, d_rr, d_sel1, d_sel2, d_resp, d_tie}, 26'd1 << 22);
        end
        s_reset = 1'b0; d_reset = 1'b0;
        step();
    endtask

    task automatic run_small(input logic [2:0] a1, input logic [2:0] a2,
                             input logic [2:0] b1, input logic [2:0] b2,
                             input logic [7:0] ca1, input logic [7:0] ca2,
                             input logic [7:0] cb1, input logic [7:0] cb2,
                             input logic [1:0] er, input logic [1:0] et,
                             input bit disturb, input bit hold_start,
                             input string name);
        logic [11:0] ch;
        logic [2:0]  e1, e2;
        logic        xen, xrr, xbusy;
        int bad_sel, bad_ctl, en0, en1, dpos, dcnt, p, ph;
        ch = {b2, b1, a2, a1};
        bad_sel = 0; bad_ctl = 0; en0 = 0; en1 = 0; dpos = -1; dcnt = 0;
        s_chal = ch;
        s_start = 1'b1;
        step();
        if (!hold_start) s_start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) step();
            p  = (k < 28) ? k / 14 : 1;
            ph = k % 14;
            if (k <= 28) begin
                e1 = (p == 1) ? b1 : a1;
                e2 = (p == 1) ? b2 : a2;
                if (s_sel1 !== e1 || s_sel2 !== e2) bad_sel++;
            end
            xen   = (k < 28) && (ph >= 1) && (ph <= 10);
            xrr   = (k >= 28) || (ph == 0);
            xbusy = (k <= 28);
            if ({s_en, s_rr, s_busy} !== {xen, xrr, xbusy}) bad_ctl++;
            if (s_en === 1'b1) begin
                if (p == 0) en0++;
                else en1++;
            end
            if (s_done === 1'b1) begin
                dcnt++;
                dpos = k;
            end
            if (disturb && k == 3) begin
                s_start = 1'b1;
                s_chal  = ~ch;
            end
            if (disturb && k == 4) s_start = 1'b0;
            if (k < 28 && ph >= 11) begin
                s_c1 = (p == 1) ? cb1 : ca1;
                s_c2 = (p == 1) ? cb2 : ca2;
            end else begin
                s_c1 = '0;
                s_c2 = '0;
            end
        end
        total++;
        if (bad_sel != 0) begin
            fails++;
            $display("FAIL %s_sel: got %0d bad cycles want 0", name, bad_sel);
        end
        total++;
        if (bad_ctl != 0) begin
            fails++;
            $display("FAIL %s_ctl: got %0d bad cycles want 0", name, bad_ctl);
        end
        total++;
        if (en0 != 10 || en1 != 10) begin
            fails++;
            $display("FAIL %s_window: got %0d/%0d want 10/10", name, en0, en1);
        end
        total++;
        if (dcnt != 1 || dpos != 29) begin
            fails++;
            $display("FAIL %s_done: got count %0d at %0d want 1 at 29", name, dcnt, dpos);
        end
        total++;
        if (s_resp !== er || s_tie !== et) begin
            fails++;
            $display("FAIL %s_result: got %b/%b want %b/%b", name, s_resp, s_tie, er, et);
        end
        step();
        if (hold_start) begin
            total++;
            if ({s_busy, s_rr, s_en, s_sel1, s_sel2} !== {3'b110, a1, a2}) begin
                fails++;
                $display("FAIL %s_restart: got %b want %b", name,
                         {s_busy, s_rr, s_en, s_sel1, s_sel2}, {3'b110, a1, a2});
            end
            s_start = 1'b0;
            s_reset = 1'b1;
            step();
            s_reset = 1'b0;
            step();
        end else begin
            total++;
            if ({s_resp, s_tie, s_busy, s_done} !== {er, et, 2'b00}) begin
                fails++;
                $display("FAIL %s_hold: got %b want %b", name,
                         {s_resp, s_tie, s_busy, s_done}, {er, et, 2'b00});
            end
        end
        s_chal = '0;
    endtask

    task automatic test_run();
        run_small(3'd0, 3'd1, 3'd2, 3'd3, 8'h50, 8'h40, 8'h30, 8'h31,
                  2'b01, 2'b00, 1'b0, 1'b0, "run");
    endtask

    task automatic test_tie();
        run_small(3'd5, 3'd5, 3'd7, 3'd0, 8'h7F, 8'h7F, 8'h10, 8'h20,
                  2'b00, 2'b01, 1'b0, 1'b0, "tie");
    endtask

    task automatic test_busy_protect();
        run_small(3'd4, 3'd6, 3'd1, 3'd7, 8'h20, 8'h21, 8'h99, 8'h98,
                  2'b10, 2'b00, 1'b1, 1'b0, "busy");
    endtask

    task automatic test_reset_mid();
        int dcnt, bcnt;
        dcnt = 0; bcnt = 0;
        s_chal = 12'hABC;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        repeat (5) step();
        s_reset = 1'b1;
        step();
        total++;
        if ({s_en, s_rr, s_busy, s_done} !== 4'b0100) begin
            fails++;
            $display("FAIL rstmid_ctl: got %b want 0100", {s_en, s_rr, s_busy, s_done});
        end
        total++;
        if ({s_sel1, s_sel2, s_resp, s_tie} !== 10'd0) begin
            fails++;
            $display("FAIL rstmid_data: got %h want 0", {s_sel1, s_sel2, s_resp, s_tie});
        end
        s_reset = 1'b0;
        repeat (40) begin
            step();
            if (s_done === 1'b1) dcnt++;
            if (s_busy === 1'b1) bcnt++;
        end
        total++;
        if (dcnt != 0 || bcnt != 0) begin
            fails++;
            $display("FAIL rstmid_quiet: got done %0d busy %0d want 0 0", dcnt, bcnt);
        end
        run_small(3'd6, 3'd2, 3'd3, 3'd5, 8'hE0, 8'h0E, 8'h40, 8'h40,
                  2'b01, 2'b10, 1'b0, 1'b0, "rstrun");
    endtask

    task automatic test_back_to_back();
        run_small(3'd1, 3'd2, 3'd4, 3'd3, 8'h05, 8'h06, 8'hF0, 8'h0F,
                  2'b10, 2'b00, 1'b0, 1'b1, "b2b");
    endtask

    task automatic test_sequencing();
        logic [47:0] ch;
        logic        xen, xrr, xbusy;
        int bad_sel, bad_ctl, rr_mid, dpos, dcnt, p, ph;
        bad_sel = 0; bad_ctl = 0; rr_mid = 0; dpos = -1; dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            ch[6*i +: 3]     = 3'(i);
            ch[6*i + 3 +: 3] = 3'(7 - i);
        end
        d_chal = ch;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        for (int k = 0; k < 1651; k++) begin
            if (k > 0) step();
            p  = (k < 1648) ? k / 206 : 7;
            ph = k % 206;
            if (k <= 1648) begin
                if (d_sel1 !== 3'(p) || d_sel2 !== 3'(7 - p)) bad_sel++;
            end
            xen   = (k < 1648) && (ph >= 1) && (ph <= 200);
            xrr   = (k >= 1648) || (ph == 0);
            xbusy = (k <= 1648);
            if ({d_en, d_rr, d_busy} !== {xen, xrr, xbusy}) bad_ctl++;
            if (k >= 1 && k < 1648 && d_rr === 1'b1) rr_mid++;
            if (d_done === 1'b1) begin
                dcnt++;
                dpos = k;
            end
            if (k < 1648 && ph >= 201) begin
                d_c1 = dc1[p];
                d_c2 = dc2[p];
            end else begin
                d_c1 = '0;
                d_c2 = '0;
            end
        end
        total++;
        if (bad_sel != 0) begin
            fails++;
            $display("FAIL seq_sel: got %0d bad cycles want 0", bad_sel);
        end
        total++;
        if (bad_ctl != 0) begin
            fails++;
            $display("FAIL seq_ctl: got %0d bad cycles want 0", bad_ctl);
        end
        total++;
        if (rr_mid != 7) begin
            fails++;
            $display("FAIL seq_rr_gap: got %0d want 7", rr_mid);
        end
        total++;
        if (dcnt != 1 || dpos != 1649) begin
            fails++;
            $display("FAIL seq_done: got count %0d at %0d want 1 at 1649", dcnt, dpos);
        end
        total++;
        if (d_resp !== 8'hA5 || d_tie !== 8'h08) begin
            fails++;
            $display("FAIL seq_result: got %h/%h want a5/08", d_resp, d_tie);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_tie();
        test_busy_protect();
        test_reset_mid();
        test_back_to_back();
        test_sequencing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
        $finish;
    end

endmodule
